// File: rtl/bp_ctrl.sv
// Branch-prediction controller: tracks in-flight predictions in order, pairs them
// with EX resolutions, and raises flush/redirect, predictor-update strobes and counters.
module bp_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid_i,
    input  logic [ADDR_W-1:0] pred_addr_i,
    input  logic              pred_taken_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    input  logic              res_valid_i,
    input  logic              res_taken_i,
    input  logic [ADDR_W-1:0] res_target_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              upd_valid_o,
    output logic [ADDR_W-1:0] upd_addr_o,
    output logic              upd_taken_o,
    output logic              err_o,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       mispred_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL_CNT   = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

    logic [ADDR_W-1:0] addr_mem   [DEPTH];
    logic              taken_mem  [DEPTH];
    logic [ADDR_W-1:0] target_mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic              do_pop, do_push, mispredict, empty_res;
    logic [ADDR_W-1:0] head_addr, head_target, correct_pc;
    logic              head_taken;

    assign head_addr   = addr_mem[rd_ptr];
    assign head_taken  = taken_mem[rd_ptr];
    assign head_target = target_mem[rd_ptr];

    // While flush_o is high the inputs belong to the squashed wrong path.
    assign do_pop    = res_valid_i && !flush_o && (count != '0);
    assign do_push   = pred_valid_i && !flush_o && ((count != FULL_CNT) || do_pop);
    assign empty_res = res_valid_i && !flush_o && (count == '0);

    assign mispredict = do_pop && ((head_taken != res_taken_i) ||
                                   (res_taken_i && (head_target != res_target_i)));
    assign correct_pc = res_taken_i ? res_target_i : head_addr + INSN_BYTES;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);

    // NOTE: the payload array has no reset; count and pointers alone define which
    // entries are valid, so clearing storage would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr]   <= pred_addr_i;
            taken_mem[wr_ptr]  <= pred_taken_i;
            target_mem[wr_ptr] <= pred_target_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every process
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            // Squash everything, including a push presented in the same cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_o         <= 1'b0;
            redirect_addr_o <= '0;
            upd_valid_o     <= 1'b0;
            upd_addr_o      <= '0;
            upd_taken_o     <= 1'b0;
            err_o           <= 1'b0;
            branch_cnt_o    <= '0;
            mispred_cnt_o   <= '0;
        end else begin
            flush_o         <= mispredict;
            redirect_addr_o <= mispredict ? correct_pc : '0;
            upd_valid_o     <= do_pop;
            upd_addr_o      <= do_pop ? head_addr : '0;
            upd_taken_o     <= do_pop && res_taken_i;
            if (empty_res)  err_o         <= 1'b1;
            if (do_pop)     branch_cnt_o  <= branch_cnt_o + 32'd1;
            if (mispredict) mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_bp_ctrl.sv
// Self-checking bench for bp_ctrl: a queue-based reference model predicts each
// strobe at resolution time and a scoreboard compares it the cycle after.
module tb_bp_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic [31:0] target;
    } pred_t;

    typedef struct {
        logic        flush;
        logic [31:0] redirect;
        logic [31:0] addr;
        logic        taken;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              pred_valid_i, pred_taken_i, res_valid_i, res_taken_i;
    logic [ADDR_W-1:0] pred_addr_i, pred_target_i, res_target_i;
    logic              full_o, empty_o, flush_o, upd_valid_o, upd_taken_o, err_o;
    logic [ADDR_W-1:0] redirect_addr_o, upd_addr_o;
    logic [31:0]       branch_cnt_o, mispred_cnt_o;

    bp_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid_i(pred_valid_i), .pred_addr_i(pred_addr_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
        .full_o(full_o), .empty_o(empty_o), .flush_o(flush_o),
        .redirect_addr_o(redirect_addr_o), .upd_valid_o(upd_valid_o),
        .upd_addr_o(upd_addr_o), .upd_taken_o(upd_taken_o), .err_o(err_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    pred_t       m_q[$];
    exp_t        sb[$];
    logic        m_flush;
    logic        m_err;
    logic [31:0] m_bcnt, m_mcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("upd_valid", 32'(upd_valid_o), 32'd1);
        end else begin
            e = '{flush: 1'b0, redirect: 32'd0, addr: 32'd0, taken: 1'b0};
            check("upd_valid", 32'(upd_valid_o), 32'd0);
        end
        check("upd_addr", upd_addr_o, e.addr);
        check("upd_taken", 32'(upd_taken_o), 32'(e.taken));
        check("flush", 32'(flush_o), 32'(e.flush));
        check("redirect", redirect_addr_o, e.redirect);
        check("empty", 32'(empty_o), 32'(m_q.size() == 0));
        check("full", 32'(full_o), 32'(m_q.size() == DEPTH));
        check("err", 32'(err_o), 32'(m_err));
        check("branch_cnt", branch_cnt_o, m_bcnt);
        check("mispred_cnt", mispred_cnt_o, m_mcnt);
    endtask

    // One clock: drive inputs, advance the model across the edge, then check.
    task automatic cycle(input logic pv, input logic [31:0] pa, input logic pt,
                         input logic [31:0] ptg, input logic rv, input logic rt,
                         input logic [31:0] rtg);
        int    pre;
        logic  pop, mis;
        pred_t h;
        pred_after: begin end
        pred_valid_i = pv; pred_addr_i = pa; pred_taken_i = pt; pred_target_i = ptg;
        res_valid_i  = rv; res_taken_i = rt; res_target_i = rtg;
        pre = m_q.size();
        pop = rv && !m_flush && (pre > 0);
        mis = 1'b0;
        if (rv && !m_flush && pre == 0) m_err = 1'b1;
        if (pop) begin
            h   = m_q.pop_front();
            mis = (h.taken != rt) || (rt && h.target != rtg);
            m_bcnt++;
            if (mis) m_mcnt++;
            sb.push_back('{flush: mis,
                           redirect: mis ? (rt ? rtg : h.addr + 32'd4) : 32'd0,
                           addr: h.addr, taken: rt});
        end
        if (mis) m_q.delete();
        else if (pv && !m_flush && (pre < DEPTH || pop))
            m_q.push_back('{addr: pa, taken: pt, target: ptg});
        m_flush = mis;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic push(input logic [31:0] a, input logic t, input logic [31:0] tg);
        cycle(1'b1, a, t, tg, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, t, tg);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pred_valid_i = 1'b0; pred_addr_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;
        res_valid_i  = 1'b0; res_taken_i = 1'b0; res_target_i = '0;
        m_q.delete(); sb.delete();
        m_flush = 1'b0; m_err = 1'b0; m_bcnt = '0; m_mcnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        do_reset();
        idle(); idle();

        // Correct taken prediction.
        push(32'h100, 1'b1, 32'h80);
        resolve(1'b1, 32'h80);
        idle();

        // Predicted not-taken, actually taken.
        push(32'h200, 1'b0, 32'h0);
        resolve(1'b1, 32'h240);
        idle();
        // Predicted taken, actually not-taken.
        push(32'h200, 1'b1, 32'h240);
        resolve(1'b0, 32'h0);
        idle();
        // Both taken, target differs.
        push(32'h500, 1'b1, 32'h600);
        resolve(1'b1, 32'h604);
        idle();
        // Fall-through PC wraps at 2^32.
        push(32'hFFFF_FFFC, 1'b1, 32'h8);
        resolve(1'b0, 32'h0);
        idle();

        // Fill, drop at full, push+pop at full, drain with pointer wrap.
        for (int i = 1; i <= 4; i++) push(32'(i * 16), 1'b0, 32'h0);
        push(32'h60, 1'b0, 32'h0);
        cycle(1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) resolve(1'b0, 32'h0);
        idle();

        // Mispredict with a same-cycle push, then wrong-path inputs during flush.
        push(32'h1000, 1'b1, 32'h2000);
        push(32'h1004, 1'b0, 32'h0);
        push(32'h1008, 1'b0, 32'h0);
        cycle(1'b1, 32'h100C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000);
        idle();

        // Resolution with nothing in flight sets the sticky error.
        resolve(1'b1, 32'h44);
        idle(); idle();

        // Reset mid-operation.
        push(32'h700, 1'b0, 32'h0);
        push(32'h704, 1'b0, 32'h0);
        do_reset();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_ctrl.md
Name: bp_ctrl

Overview:
- Branch-prediction controller between IF/ID and EX. Records every prediction issued by the branch predictor in an in-order in-flight queue.
- When EX resolves each branch, it pairs the resolution with the oldest queued prediction and detects mispredicts.
- On a mispredict it drives pipeline flush/redirect.
- It issues one-cycle update strobes (last_need_predict/last_addr/last_jump) to the predictor tables and keeps branch/mispredict performance counters.

Parameters:
- DEPTH, 4, in-flight queue entries; power of 2, >=2
- ADDR_W, 32, instruction address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pred_valid_i  in  1  predictor issued a prediction for a branch/JAL this cycle
- pred_addr_i  in  ADDR_W  address of predicted instruction
- pred_taken_i  in  1  predicted direction
- pred_target_i  in  ADDR_W  predicted target (don't-care if not taken)
- res_valid_i  in  1  EX resolved the oldest in-flight branch this cycle
- res_taken_i  in  1  actual direction
- res_target_i  in  ADDR_W  actual target
- full_o  out  1  queue holds DEPTH entries; IF must stall predicted fetch
- empty_o  out  1  queue holds 0 entries
- flush_o  out  1  mispredict; flush IF/ID, one-cycle pulse
- redirect_addr_o  out  ADDR_W  correct next PC while flush_o=1, else 0
- upd_valid_o  out  1  predictor update strobe (to last_need_predict)
- upd_addr_o  out  ADDR_W  resolved branch address (to last_addr), 0 when !upd_valid_o
- upd_taken_o  out  1  actual direction (to last_jump), 0 when !upd_valid_o
- err_o  out  1  sticky: resolution arrived with empty queue
- branch_cnt_o  out  32  resolved branches
- mispred_cnt_o  out  32  mispredicted branches

Behaviour:
- Reset (sync, rst=1 at posedge):
  - queue empty, read/write pointers 0, empty_o=1, full_o=0
  - all other outputs 0, counters 0, err_o 0
  - rst mid-operation discards all in-flight entries and pending strobes.
- Queue: circular buffer of {addr, taken, target}; count 0..DEPTH; pointers wrap modulo DEPTH. full_o/empty_o decode registered count only, no input dependency.
- Push: pred_valid_i=1 and flush_o=0 and (count<DEPTH, or a valid pop in the same cycle).
  - Push at full with no pop: dropped, count unchanged. The IF stall via full_o prevents this in normal operation.
- Pop: res_valid_i=1, flush_o=0, count>0. Head is compared with the resolution:
  - mispredict = (head.taken != res_taken_i) or (res_taken_i and head.target != res_target_i)
  - correct PC = res_taken_i ? res_target_i : head.addr + 4 (mod 2^ADDR_W)
- Outputs are registered and valid the cycle after the pop:
  - upd_valid_o=1, upd_addr_o=head.addr, upd_taken_o=res_taken_i, all for exactly one cycle
  - on mispredict, additionally flush_o=1 and redirect_addr_o=correct PC for one cycle
- Mispredict squash:
  - At the pop edge, the whole queue is cleared (count=0, pointers=0), including any push presented the same cycle.
  - During the cycle flush_o=1, pred_valid_i and res_valid_i are ignored (wrong path).
- Simultaneous push+pop, no mispredict: both take effect; count unchanged; at full, the freed slot is reused.
- Resolution with empty queue (res_valid_i=1, count=0, flush_o=0):
  - ignored; no strobe, no counter change
  - err_o set, held until rst
- Counters:
  - branch_cnt_o +1 per accepted pop
  - mispred_cnt_o +1 per mispredict
  - both wrap at 2^32; updated at the pop edge

Test Plan:
- Reset, then idle -> empty_o=1, full_o=0, flush_o=0, upd_valid_o=0, all counters 0.
- Push {0x100, taken, 0x80}; next cycle resolve taken, 0x80 -> cycle after: upd_valid_o=1, upd_addr_o=0x100, upd_taken_o=1, flush_o=0; branch_cnt_o=1, mispred_cnt_o=0.
- Push {0x200, not-taken}, resolve taken, 0x240 -> flush_o=1, redirect_addr_o=0x240, mispred_cnt_o=1. Repeat with predicted taken, resolved not-taken -> redirect_addr_o=0x204.
- Push 4 entries (0x10, 0x20, 0x30, 0x40), all correct -> full_o=1. Push 0x50 while resolving 0x10 -> count stays 4. Resolve remaining four in order -> upd_addr_o sequence 0x20, 0x30, 0x40, 0x50; empty_o=1; pointers wrapped.
- Queue holds 3 entries, head mispredicts with a same-cycle push -> flush_o=1, empty_o=1 next cycle. pred_valid_i and res_valid_i during the flush cycle are ignored (count stays 0, no upd strobe).
- res_valid_i with empty queue -> err_o=1 (sticky), counters unchanged, no strobe. Assert rst with 2 entries queued -> empty_o=1, err_o=0, counters 0.
